sumresta_bcd_display: RTL and testbench
=======================================

Name: sumresta_bcd_display

Overview:
Parametrised signed adder/subtractor with a decimal multiplexed 7-segment readout; next generation of the 4-bit add/sub visual top.
- On a start request: captures two WIDTH-bit two's-complement operands, computes A+B or A-B at full precision and flags WIDTH-bit overflow.
- Converts the magnitude to BCD with a sequential double-dabble engine.
- Scans DIGITS common-anode digits with a sign digit and leading-zero blanking.
- Generates its own scan rate internally; no external clock divider.

Parameters:
- WIDTH, 4: operand width, signed; legal 2..12.
- DIGITS, 4: number of display digits; must satisfy 2^WIDTH < 10^(DIGITS-1).
- REFRESH_DIV, 50000: clk cycles each digit stays active; legal >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- A  in  WIDTH  operand A, signed.
- B  in  WIDTH  operand B, signed.
- Sel  in  1  0 = add, 1 = subtract.
- start  in  1  request; sampled only while idle.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when display registers update.
- ovf  out  1  result not representable in WIDTH signed bits.
- SSeg  out  [0:6]  segments a..g, active-low.
- an  out  DIGITS  digit enables, active-low; an[0] = rightmost digit.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.
- While rst is high: FSM = IDLE; busy = 0; done = 0; ovf = 0; stored value = +0; scan counter and digit index = 0; an = all 1; SSeg = all 1.
- After release, digit 0 shows "0".
FSM states:
- IDLE: start=1 captures A, B, Sel -> CALC. Otherwise stay.
- CALC (1 cycle): R = sext(A) +/- sext(B) in WIDTH+1 bits. Stores sign = R[WIDTH], mag = |R| (WIDTH+1 bits, unsigned), ovf_next = (R outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]). Clears BCD shift register -> SHIFT.
- SHIFT (WIDTH+1 cycles): each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, taking the MSB of mag -> DONE after the last shift.
- DONE (1 cycle): copies BCD digits, sign and ovf into display registers; done = 1 -> IDLE.
Timing:
- busy = 1 in CALC, SHIFT and DONE.
- done is high exactly WIDTH+3 cycles after the start sampling edge; 7 cycles for WIDTH = 4.
- A/B/Sel changes after capture have no effect.
- start while busy is ignored, not queued.
- Reset mid-conversion aborts. No done pulse; display returns to 0.
- Result 0 is always positive: sign = 0.
Display:
- Scan counter counts 0..REFRESH_DIV-1; at wrap, digit index advances modulo DIGITS.
- Exactly one an bit is low at a time, outside reset.
- Digit DIGITS-1 shows "-" (SSeg = 1111110) when sign = 1, blank otherwise.
- Digits 0..DIGITS-2 show BCD values with leading zeros blanked (SSeg = 1111111). Digit 0 is never blanked.
- Display registers change only in DONE, so no tearing mid-scan.

Optional Feature:
- Macro: SUMRESTA_OVF_BLINK_EN.
- Defined: while displayed ovf = 1, all anodes are forced off during alternate 256-scan-tick phases, driven by an 8-bit blink counter cleared by rst.
- Undefined: no blink counter; ovf is reported only on the ovf port. The display is unaffected.

Decomposition:
- Package sumresta_pkg holds:
  - state enum: IDLE, CALC, SHIFT, DONE;
  - SEG_BLANK = 7'b1111111 and SEG_MINUS = 7'b1111110;
  - a function mapping a 4-bit digit to its active-low 7-segment code.
- One sub-module: seg7_scan.
  - Contains the refresh counter, digit index, anode decode, blanking and segment lookup.
  - Parametrised by DIGITS and REFRESH_DIV.
  - Takes the BCD vector and sign; holds the optional blink logic.
- FSM, arithmetic and double-dabble stay in the top.

Test Plan:
Bench settings: WIDTH = 4, DIGITS = 4, REFRESH_DIV = 4.
1. A=3, B=4, Sel=0, start -> done 7 cycles later; ovf = 0; digits (3..0) = blank, blank, blank, "7".
2. A=2, B=5, Sel=1 -> value -3; digit3 = "-" (1111110); digit0 = "3"; digits 1-2 blank; ovf = 0.
3. A=7, B=7, Sel=0 -> 14; ovf = 1; digit1 = "1", digit0 = "4". Follow with A=-8, B=-8, Sel=0 -> "-16", ovf = 1. With SUMRESTA_OVF_BLINK_EN, anodes go fully off for 256-tick phases.
4. A=-8, B=-8, Sel=1 -> 0; sign blank; digit0 = "0"; ovf = 0.
5. start pulsed on cycle 3 of a conversion -> ignored: exactly one done and unchanged result. rst asserted during SHIFT -> busy = 0 immediately, no done, an = 1111, display then shows "0".
6. Idle scan after reset release -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, repeating; never two bits low.

Source files
------------

// File: rtl/sumresta_pkg.sv
// rtl/sumresta_pkg.sv - shared types, segment constants and digit decoder for sumresta_bcd_display
package sumresta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Segment codes are ordered a..g from MSB to LSB, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    // Decimal digit to active-low a..g pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg7_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sumresta_bcd_display_if.sv
// rtl/sumresta_bcd_display_if.sv - operand/request/status bundle for sumresta_bcd_display
interface sumresta_bcd_display_if #(
    parameter int WIDTH = 4
);
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic                    Sel;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    ovf;

    modport master (output A, B, Sel, start, input busy, done, ovf);
    modport slave  (input A, B, Sel, start, output busy, done, ovf);
endinterface

// File: rtl/sumresta_bcd_display_seg7_scan.sv
// rtl/sumresta_bcd_display_seg7_scan.sv - multiplexed 7-segment scanner with sign digit, blanking, optional SUMRESTA_OVF_BLINK_EN blink
module seg7_scan
    import sumresta_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(DIGITS-1)*4-1:0] bcd,
    input  logic                    sign,
    input  logic                    ovf,
    output logic [0:6]              SSeg,
    output logic [DIGITS-1:0]       an
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    logic [RW-1:0]     scan_cnt;
    logic [IW-1:0]     idx;
    logic              tick;
    logic [DIGITS-2:0] blank;
    logic              seen;
    logic [6:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;

    assign tick = (scan_cnt == RW'(REFRESH_DIV - 1));

    // Refresh divider and digit index advance once per divider wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SUMRESTA_OVF_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_phase;

    // Counts scan ticks; phase flips every 256 ticks to gate the anodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_cnt == 8'hFF) blink_phase <= ~blink_phase;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

    // Leading-zero blanking, segment selection and anode decode for the active digit.
    always_comb begin
        blank  = '0;
        seen   = 1'b0;
        seg_nx = SEG_BLANK;
        for (int i = DIGITS - 2; i >= 0; i--) begin
            seen     = seen | (bcd[i*4 +: 4] != 4'd0);
            blank[i] = !seen && (i != 0);
        end
        if (idx == IW'(DIGITS - 1)) begin
            seg_nx = sign ? SEG_MINUS : SEG_BLANK;
        end else begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                if (idx == IW'(i))
                    seg_nx = blank[i] ? SEG_BLANK : seg7_code(bcd[i*4 +: 4]);
            end
        end
        an_nx = ~(DIGITS'(1) << idx);
`ifdef SUMRESTA_OVF_BLINK_EN
        if (ovf && blink_phase) an_nx = '1;
`endif
    end

    // Registered outputs so everything is dark while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SSeg <= SEG_BLANK;
            an   <= '1;
        end else begin
            SSeg <= seg_nx;
            an   <= an_nx;
        end
    end

endmodule

// File: rtl/sumresta_bcd_display.sv
// rtl/sumresta_bcd_display.sv - signed add/sub with double-dabble BCD and scanned readout (SUMRESTA_OVF_BLINK_EN adds overflow blink)
module sumresta_bcd_display
    import sumresta_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    sumresta_bcd_display_if.slave bus,
    output logic [0:6]            SSeg,
    output logic [DIGITS-1:0]     an
);
    localparam int NB = (DIGITS - 1) * 4;
    localparam int CW = $clog2(WIDTH + 2);

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] a_q, b_q;
    logic                    sel_q;
    logic signed [WIDTH:0]   a_ext, b_ext, res;
    logic [WIDTH:0]          mag_q;
    logic                    sign_q, ovf_q;
    logic [NB-1:0]           bcd_q, bcd_adj, disp_bcd;
    logic                    disp_sign, disp_ovf, done_q;
    logic [CW-1:0]           shift_cnt;
    logic                    last_shift;

    assign a_ext      = {a_q[WIDTH-1], a_q};
    assign b_ext      = {b_q[WIDTH-1], b_q};
    assign res        = sel_q ? (a_ext - b_ext) : (a_ext + b_ext);
    assign last_shift = (shift_cnt == CW'(WIDTH));

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = disp_ovf;

    // Double-dabble correction: bump every BCD nibble of 5 or more by 3 before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS - 1; i++)
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = CALC;
            CALC:  state_nx = SHIFT;
            SHIFT: if (last_shift) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, arithmetic, BCD shifting and display register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= 1'b0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            shift_cnt <= '0;
            disp_bcd  <= '0;
            disp_sign <= 1'b0;
            disp_ovf  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a_q   <= bus.A;
                    b_q   <= bus.B;
                    sel_q <= bus.Sel;
                end
                CALC: begin
                    sign_q    <= res[WIDTH];
                    mag_q     <= res[WIDTH] ? $unsigned(-res) : $unsigned(res);
                    ovf_q     <= res[WIDTH] ^ res[WIDTH-1];
                    bcd_q     <= '0;
                    shift_cnt <= '0;
                end
                SHIFT: begin
                    bcd_q     <= {bcd_adj[NB-2:0], mag_q[WIDTH]};
                    mag_q     <= {mag_q[WIDTH-1:0], 1'b0};
                    shift_cnt <= shift_cnt + 1'b1;
                end
                DONE: begin
                    disp_bcd  <= bcd_q;
                    disp_sign <= sign_q;
                    disp_ovf  <= ovf_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    seg7_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .bcd  (disp_bcd),
        .sign (disp_sign),
        .ovf  (disp_ovf),
        .SSeg (SSeg),
        .an   (an)
    );

endmodule

// File: tb/tb_sumresta_bcd_display.sv
// tb/tb_sumresta_bcd_display.sv - directed self-checking bench for sumresta_bcd_display
module tb_sumresta_bcd_display;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b1111110;
    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b1001111;
    localparam logic [6:0] D3 = 7'b0000110;
    localparam logic [6:0] D4 = 7'b1001100;
    localparam logic [6:0] D6 = 7'b0100000;
    localparam logic [6:0] D7 = 7'b0001111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:6] sseg;
    logic [3:0] an;
    logic [6:0] dig [4];
    int         n_pass  = 0;
    int         n_total = 0;

    sumresta_bcd_display_if #(.WIDTH(4)) bus ();

    sumresta_bcd_display #(
        .WIDTH       (4),
        .DIGITS      (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .SSeg (sseg),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sel, output int lat);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Sel = sel; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic read_digits();
        for (int k = 0; k < 4; k++) dig[k] = 'x;
        repeat (2) @(negedge clk);
        repeat (24) begin
            @(negedge clk);
            case (an)
                4'b1110: dig[0] = sseg;
                4'b1101: dig[1] = sseg;
                4'b1011: dig[2] = sseg;
                4'b0111: dig[3] = sseg;
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        read_digits();
        check({tag, ".d3"}, 32'(dig[3]), 32'(e3));
        check({tag, ".d2"}, 32'(dig[2]), 32'(e2));
        check({tag, ".d1"}, 32'(dig[1]), 32'(e1));
        check({tag, ".d0"}, 32'(dig[0]), 32'(e0));
    endtask

    initial begin
        int         lat;
        int         done_cnt;
        logic [3:0] exp_an;

        bus.A = '0; bus.B = '0; bus.Sel = 1'b0; bus.start = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.ovf",  32'(bus.ovf),  32'd0);
        check("rst.an",   32'(an),       32'hF);
        check("rst.sseg", 32'(sseg),     32'(BL));

        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check("scan.an", 32'(an), 32'(exp_an));
        end

        run_op(4'd3, 4'd4, 1'b0, lat);
        check("t1.lat", 32'(lat), 32'd7);
        check("t1.busy", 32'(bus.busy), 32'd0);
        check("t1.ovf", 32'(bus.ovf), 32'd0);
        check_disp("t1", BL, BL, BL, D7);

        run_op(4'd2, 4'd5, 1'b1, lat);
        check("t2.lat", 32'(lat), 32'd7);
        check("t2.ovf", 32'(bus.ovf), 32'd0);
        check_disp("t2", MI, BL, BL, D3);

        run_op(4'd7, 4'd7, 1'b0, lat);
        check("t3a.ovf", 32'(bus.ovf), 32'd1);
        check_disp("t3a", BL, BL, D1, D4);

        run_op(4'b1000, 4'b1000, 1'b0, lat);
        check("t3b.ovf", 32'(bus.ovf), 32'd1);
        check_disp("t3b", MI, BL, D1, D6);

        run_op(4'b1000, 4'b1000, 1'b1, lat);
        check("t4.ovf", 32'(bus.ovf), 32'd0);
        check_disp("t4", BL, BL, BL, D0);

        // Second start mid-conversion plus operand changes after capture.
        @(negedge clk);
        bus.A = 4'd1; bus.B = 4'd2; bus.Sel = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd5;
            end else if (n == 3) begin
                bus.start = 1'b0;
            end
            if (bus.done) done_cnt++;
        end
        check("t5.dones", 32'(done_cnt), 32'd1);
        check_disp("t5", BL, BL, BL, D3);

        // Reset during SHIFT aborts and clears the display.
        @(negedge clk);
        bus.A = 4'd6; bus.B = 4'd1; bus.Sel = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5r.busy", 32'(bus.busy), 32'd0);
        check("t5r.an",   32'(an),       32'hF);
        check("t5r.sseg", 32'(sseg),     32'(BL));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("t5r.dones", 32'(done_cnt), 32'd0);
        check("t5r.ovf", 32'(bus.ovf), 32'd0);
        check_disp("t5r", BL, BL, BL, D0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
